// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_if
// Brief    : Hazard inputs and register enable/flush outputs of the stall scheduler
// Revision : 1.0
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [2:0]       IFID_rs;
    logic [2:0]       IFID_rt;
    logic             IFID_rs_used;
    logic             IFID_rt_used;
    logic             IDEX_MemRead;
    logic             IDEX_RegWrite;
    logic [2:0]       IDEX_WriteRegSel;
    logic             branch_taken;
    logic             IMem_stall;
    logic             DMem_stall;
    logic             MemWB_DMemDump;
    logic             PC_en;
    logic             IFID_en;
    logic             IFID_flush;
    logic             IDEX_en;
    logic             IDEX_flush;
    logic             EXMem_en;
    logic             MemWB_en;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Pipeline side: reports hazards, consumes enables/flushes.
    modport master (
        output IFID_rs, IFID_rt, IFID_rs_used, IFID_rt_used,
        output IDEX_MemRead, IDEX_RegWrite, IDEX_WriteRegSel,
        output branch_taken, IMem_stall, DMem_stall, MemWB_DMemDump,
        input  PC_en, IFID_en, IFID_flush, IDEX_en, IDEX_flush, EXMem_en, MemWB_en,
        input  halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  IFID_rs, IFID_rt, IFID_rs_used, IFID_rt_used,
        input  IDEX_MemRead, IDEX_RegWrite, IDEX_WriteRegSel,
        input  branch_taken, IMem_stall, DMem_stall, MemWB_DMemDump,
        output PC_en, IFID_en, IFID_flush, IDEX_en, IDEX_flush, EXMem_en, MemWB_en,
        output halted, stall_cnt, flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Stall/flush scheduler for the 5-stage pipeline registers
// Revision : 1.0
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int LU_CYCLES = 1,
    parameter int CNT_W     = 16
) (
    input wire                clk,
    input wire                rst,
    pipe_hazard_ctrl_if.slave hz
);
    localparam logic [1:0]       S_RUN      = 2'd0;
    localparam logic [1:0]       S_LU_STALL = 2'd1;
    localparam logic [1:0]       S_HALTED   = 2'd2;
    localparam logic [2:0]       c_LU_INIT  = 3'(LU_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

    logic [1:0]       r_state;
    logic [1:0]       w_nextState;
    logic [2:0]       r_luCtr;
    logic [2:0]       w_nextLuCtr;
    logic             r_halted;
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_flushCnt;
    logic             w_haz;
    logic             w_pcEn;
    logic             w_ifidEn;
    logic             w_ifidFlush;
    logic             w_idexEn;
    logic             w_idexFlush;
    logic             w_exMemEn;
    logic             w_memWbEn;
    logic             w_flushInc;
    logic             w_stallInc;

    assign w_haz = hz.IDEX_MemRead & hz.IDEX_RegWrite &
                   ((hz.IFID_rs_used & (hz.IFID_rs == hz.IDEX_WriteRegSel)) |
                    (hz.IFID_rt_used & (hz.IFID_rt == hz.IDEX_WriteRegSel)));

    always_comb begin
        w_pcEn      = 1'b1;
        w_ifidEn    = 1'b1;
        w_ifidFlush = 1'b0;
        w_idexEn    = 1'b1;
        w_idexFlush = 1'b0;
        w_exMemEn   = 1'b1;
        w_memWbEn   = 1'b1;
        w_flushInc  = 1'b0;
        w_nextLuCtr = r_luCtr;
        // An unused encoding falls back to RUN.
        w_nextState = (r_state == S_HALTED || r_state == S_LU_STALL) ? r_state : S_RUN;

        if (r_state == S_HALTED) begin
            w_pcEn    = 1'b0;
            w_ifidEn  = 1'b0;
            w_idexEn  = 1'b0;
            w_exMemEn = 1'b0;
            w_memWbEn = 1'b0;
        end else if (hz.DMem_stall) begin
            w_pcEn    = 1'b0;
            w_ifidEn  = 1'b0;
            w_idexEn  = 1'b0;
            w_exMemEn = 1'b0;
            w_memWbEn = 1'b0;
        end else if (hz.MemWB_DMemDump) begin
            // Only the halt instruction retires; everything upstream freezes.
            w_pcEn      = 1'b0;
            w_ifidEn    = 1'b0;
            w_idexEn    = 1'b0;
            w_exMemEn   = 1'b0;
            w_nextState = S_HALTED;
        end else if (hz.branch_taken) begin
            w_ifidFlush = 1'b1;
            w_idexFlush = 1'b1;
            w_flushInc  = 1'b1;
            w_nextState = S_RUN;
            w_nextLuCtr = 3'd0;
        end else if (r_state == S_LU_STALL) begin
            w_pcEn      = 1'b0;
            w_ifidEn    = 1'b0;
            w_idexFlush = 1'b1;
            w_nextLuCtr = r_luCtr - 3'd1;
            if (r_luCtr == 3'd1) begin
                w_nextState = S_RUN;
            end
        end else if (w_haz) begin
            w_pcEn      = 1'b0;
            w_ifidEn    = 1'b0;
            w_idexFlush = 1'b1;
            if (LU_CYCLES > 1) begin
                w_nextState = S_LU_STALL;
                w_nextLuCtr = c_LU_INIT;
            end
        end else if (hz.IMem_stall) begin
            w_pcEn      = 1'b0;
            w_ifidFlush = 1'b1;
        end
    end

    assign w_stallInc = ~w_pcEn & (r_state != S_HALTED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_RUN;
            r_luCtr    <= 3'd0;
            r_halted   <= 1'b0;
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            r_state  <= w_nextState;
            r_luCtr  <= w_nextLuCtr;
            r_halted <= (w_nextState == S_HALTED);
            if (w_stallInc && (r_stallCnt != c_CNT_MAX)) begin
                r_stallCnt <= r_stallCnt + CNT_W'(1);
            end
            if (w_flushInc && (r_flushCnt != c_CNT_MAX)) begin
                r_flushCnt <= r_flushCnt + CNT_W'(1);
            end
        end
    end

    // Reset forces every register enable low without waiting for a clock.
    assign hz.PC_en      = w_pcEn      & ~rst;
    assign hz.IFID_en    = w_ifidEn    & ~rst;
    assign hz.IFID_flush = w_ifidFlush & ~rst;
    assign hz.IDEX_en    = w_idexEn    & ~rst;
    assign hz.IDEX_flush = w_idexFlush & ~rst;
    assign hz.EXMem_en   = w_exMemEn   & ~rst;
    assign hz.MemWB_en   = w_memWbEn   & ~rst;
    assign hz.halted     = r_halted;
    assign hz.stall_cnt  = r_stallCnt;
    assign hz.flush_cnt  = r_flushCnt;
endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Randomized bench for pipe_hazard_ctrl (LU_CYCLES=1/CNT_W=16 and
//            LU_CYCLES=3/CNT_W=4) against a cycle-level behavioural model
// Revision : 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;
    typedef struct packed {
        logic [2:0] rs;
        logic [2:0] rt;
        logic       rsU;
        logic       rtU;
        logic       memRead;
        logic       regWrite;
        logic [2:0] wsel;
        logic       br;
        logic       imem;
        logic       dmem;
        logic       dump;
    } stim_t;

    logic clk;
    logic rst;

    pipe_hazard_ctrl_if #(.CNT_W(16)) ifA ();
    pipe_hazard_ctrl_if #(.CNT_W(4))  ifB ();

    pipe_hazard_ctrl #(.LU_CYCLES(1), .CNT_W(16)) u_dutA (
        .clk (clk),
        .rst (rst),
        .hz  (ifA)
    );

    pipe_hazard_ctrl #(.LU_CYCLES(3), .CNT_W(4)) u_dutB (
        .clk (clk),
        .rst (rst),
        .hz  (ifB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: remaining bubbles, halt flag and counters per instance.
    int luCycles [2] = '{1, 3};
    int cntMax   [2] = '{65535, 15};
    int bubLeft  [2];
    bit mHalted  [2];
    int mStall   [2];
    int mFlush   [2];

    int numChecks = 0;
    int numPass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end else begin
            numPass++;
        end
    endtask

    function automatic bit isHaz(stim_t s);
        return s.memRead && s.regWrite &&
               ((s.rsU && s.rs == s.wsel) || (s.rtU && s.rt == s.wsel));
    endfunction

    // {PC_en, IFID_en, IFID_flush, IDEX_en, IDEX_flush, EXMem_en, MemWB_en}
    function automatic logic [6:0] expOut(int k, stim_t s);
        if (mHalted[k] || s.dmem)           return 7'b0000000;
        if (s.dump)                         return 7'b0000001;
        if (s.br)                           return 7'b1111111;
        if (bubLeft[k] > 0 || isHaz(s))     return 7'b0001111;
        if (s.imem)                         return 7'b0111011;
        return 7'b1101011;
    endfunction

    function automatic logic [6:0] actOut(int k);
        if (k == 0)
            return {ifA.PC_en, ifA.IFID_en, ifA.IFID_flush, ifA.IDEX_en,
                    ifA.IDEX_flush, ifA.EXMem_en, ifA.MemWB_en};
        return {ifB.PC_en, ifB.IFID_en, ifB.IFID_flush, ifB.IDEX_en,
                ifB.IDEX_flush, ifB.EXMem_en, ifB.MemWB_en};
    endfunction

    function automatic logic [31:0] actHalted(int k);
        return (k == 0) ? 32'(ifA.halted) : 32'(ifB.halted);
    endfunction

    function automatic logic [31:0] actStall(int k);
        return (k == 0) ? 32'(ifA.stall_cnt) : 32'(ifB.stall_cnt);
    endfunction

    function automatic logic [31:0] actFlush(int k);
        return (k == 0) ? 32'(ifA.flush_cnt) : 32'(ifB.flush_cnt);
    endfunction

    task automatic advance(int k, stim_t s);
        logic [6:0] o;
        o = expOut(k, s);
        if (mHalted[k]) return;
        if (!o[6]) mStall[k] = (mStall[k] < cntMax[k]) ? mStall[k] + 1 : cntMax[k];
        if (s.dmem) return;
        if (s.dump) begin
            mHalted[k] = 1'b1;
            return;
        end
        if (s.br) begin
            mFlush[k]  = (mFlush[k] < cntMax[k]) ? mFlush[k] + 1 : cntMax[k];
            bubLeft[k] = 0;
        end else if (bubLeft[k] > 0) begin
            bubLeft[k] = bubLeft[k] - 1;
        end else if (isHaz(s)) begin
            bubLeft[k] = luCycles[k] - 1;
        end
    endtask

    task automatic driveStim(stim_t s);
        ifA.IFID_rs = s.rs;            ifB.IFID_rs = s.rs;
        ifA.IFID_rt = s.rt;            ifB.IFID_rt = s.rt;
        ifA.IFID_rs_used = s.rsU;      ifB.IFID_rs_used = s.rsU;
        ifA.IFID_rt_used = s.rtU;      ifB.IFID_rt_used = s.rtU;
        ifA.IDEX_MemRead = s.memRead;  ifB.IDEX_MemRead = s.memRead;
        ifA.IDEX_RegWrite = s.regWrite; ifB.IDEX_RegWrite = s.regWrite;
        ifA.IDEX_WriteRegSel = s.wsel; ifB.IDEX_WriteRegSel = s.wsel;
        ifA.branch_taken = s.br;       ifB.branch_taken = s.br;
        ifA.IMem_stall = s.imem;       ifB.IMem_stall = s.imem;
        ifA.DMem_stall = s.dmem;       ifB.DMem_stall = s.dmem;
        ifA.MemWB_DMemDump = s.dump;   ifB.MemWB_DMemDump = s.dump;
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic cycle(stim_t s);
        driveStim(s);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("outs[%0d]", k), 32'(actOut(k)), 32'(expOut(k, s)));
            chk($sformatf("halted[%0d]", k), actHalted(k), 32'(mHalted[k]));
            chk($sformatf("stall_cnt[%0d]", k), actStall(k), 32'(mStall[k]));
            chk($sformatf("flush_cnt[%0d]", k), actFlush(k), 32'(mFlush[k]));
            advance(k, s);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset raised mid low-phase; effects must be visible before any clock edge.
    task automatic asyncReset(stim_t s);
        driveStim(s);
        #3;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_outs[%0d]", k), 32'(actOut(k)), 32'd0);
            chk($sformatf("rst_halted[%0d]", k), actHalted(k), 32'd0);
            chk($sformatf("rst_stall[%0d]", k), actStall(k), 32'd0);
            chk($sformatf("rst_flush[%0d]", k), actFlush(k), 32'd0);
            bubLeft[k] = 0;
            mHalted[k] = 1'b0;
            mStall[k]  = 0;
            mFlush[k]  = 0;
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic stim_t randStim();
        stim_t s;
        s.rs       = 3'($urandom_range(0, 3));
        s.rt       = 3'($urandom_range(0, 3));
        s.wsel     = 3'($urandom_range(0, 3));
        s.rsU      = 1'($urandom_range(0, 1));
        s.rtU      = 1'($urandom_range(0, 1));
        s.memRead  = 1'($urandom_range(0, 1));
        s.regWrite = ($urandom_range(0, 3) != 0);
        s.br       = ($urandom_range(0, 7) == 0);
        s.imem     = ($urandom_range(0, 6) == 0);
        s.dmem     = ($urandom_range(0, 7) == 0);
        s.dump     = ($urandom_range(0, 99) == 0);
        return s;
    endfunction

    initial begin
        stim_t s;
        stim_t h;
        int    haltRun;

        rst = 1'b1;
        driveStim('0);
        @(negedge clk);
        asyncReset('0);

        // Load to r3 in EX while decode reads r3 as rs.
        h = '0;
        h.rs = 3'd3; h.rt = 3'd5; h.rsU = 1'b1;
        h.memRead = 1'b1; h.regWrite = 1'b1; h.wsel = 3'd3;
        cycle(h);
        repeat (3) cycle('0);

        // Branch resolved during the second bubble.
        cycle(h);
        s = '0; s.br = 1'b1;
        cycle(s);
        repeat (2) cycle('0);

        // Data-memory wait while two bubbles remain.
        cycle(h);
        s = '0; s.dmem = 1'b1;
        repeat (4) cycle(s);
        repeat (3) cycle('0);

        // Matching registers but no source used: no stall; then IMem wait alone.
        s = h; s.rsU = 1'b0; s.rtU = 1'b0; s.rt = 3'd3;
        cycle(s);
        s = '0; s.imem = 1'b1;
        cycle(s);

        // Halt held off by a data-memory wait, then drains and stays halted.
        s = '0; s.dump = 1'b1; s.dmem = 1'b1;
        repeat (2) cycle(s);
        s.dmem = 1'b0;
        cycle(s);
        repeat (3) cycle(randStim());
        asyncReset('0);

        // Long fetch wait saturates the narrow counter.
        s = '0; s.imem = 1'b1;
        repeat (20) cycle(s);
        cycle('0);

        haltRun = 0;
        for (int i = 0; i < 3000; i++) begin
            if (mHalted[0] && mHalted[1]) haltRun++;
            else haltRun = 0;
            if (haltRun > 4 || $urandom_range(0, 199) == 0) begin
                asyncReset(randStim());
                haltRun = 0;
            end else begin
                cycle(randStim());
            end
        end

        s = '0; s.imem = 1'b1;
        repeat (3) cycle(s);
        asyncReset(s);
        cycle('0);

        $display("%0d/%0d checks passed", numPass, numChecks);
        $finish;
    end
endmodule
`default_nettype wire
